// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge: FSM states,
// HTRANS codes, peripheral address windows and one-hot select codes.
package ahb_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_READ,
      ST_WRITE,
      ST_WRITEP,
      ST_RENABLE,
      ST_WENABLE,
      ST_WENABLEP
   } state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [31:0] RGN0_BASE = 32'h8000_0000;
   localparam logic [31:0] RGN1_BASE = 32'h8400_0000;
   localparam logic [31:0] RGN2_BASE = 32'h8800_0000;
   localparam logic [31:0] RGN_LIMIT = 32'h8C00_0000;

   localparam logic [2:0] SEL_NONE = 3'b000;
   localparam logic [2:0] SEL_P0   = 3'b001;
   localparam logic [2:0] SEL_P1   = 3'b010;
   localparam logic [2:0] SEL_P2   = 3'b100;

   // Out-of-window addresses decode to SEL_NONE, which also marks them invalid.
   function automatic logic [2:0] sel_of(input logic [31:0] a);
      if (a >= RGN0_BASE && a < RGN1_BASE) return SEL_P0;
      if (a >= RGN1_BASE && a < RGN2_BASE) return SEL_P1;
      if (a >= RGN2_BASE && a < RGN_LIMIT) return SEL_P2;
      return SEL_NONE;
   endfunction

endpackage

// File: rtl/ahb_apb_bridge_slave_if.sv
// AHB slave front end: address/data/direction pipeline registers and the
// transfer-valid qualifier for the bridge FSM.
module ahb_slave_if
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hwrite_i,
   input  logic              hreadyin_i,
   input  logic [1:0]        htrans_i,
   input  logic [ADDR_W-1:0] haddr_i,
   input  logic [DATA_W-1:0] hwdata_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] haddr1_o,
   output logic [ADDR_W-1:0] haddr2_o,
   output logic [DATA_W-1:0] hwdata1_o,
   output logic              hwrite_reg_o
);

   logic [ADDR_W-1:0] haddr1_q, haddr2_q;
   logic [DATA_W-1:0] hwdata1_q;
   logic              hwrite_q;
   logic [2:0]        tempselx;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         haddr1_q  <= '0;
         haddr2_q  <= '0;
         hwdata1_q <= '0;
         hwrite_q  <= 1'b0;
      end else begin
         haddr1_q  <= haddr_i;
         haddr2_q  <= haddr1_q;
         hwdata1_q <= hwdata_i;
         hwrite_q  <= hwrite_i;
      end
   end

   assign tempselx = sel_of(haddr_i);
   assign valid_o  = hreadyin_i && (htrans_i == HTRANS_NONSEQ || htrans_i == HTRANS_SEQ)
                     && (tempselx != SEL_NONE);

   assign haddr1_o     = haddr1_q;
   assign haddr2_o     = haddr2_q;
   assign hwdata1_o    = hwdata1_q;
   assign hwrite_reg_o = hwrite_q;

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: FSM sequencing APB SETUP/ACCESS per
// transfer, with registered APB outputs and AHB wait-state insertion.
module ahb_apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              hwrite,
   input  logic              hreadyin,
   input  logic [1:0]        htrans,
   input  logic [DATA_W-1:0] hwdata,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [DATA_W-1:0] prdata,
   output logic              penable,
   output logic              pwrite,
   output logic              hreadyout,
   output logic [2:0]        pselx,
   output logic [1:0]        hresp,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] hrdata
);

   logic              valid, hwrite_reg;
   logic [ADDR_W-1:0] haddr_1, haddr_2;
   logic [DATA_W-1:0] hwdata_1;

   ahb_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slave_if (
      .clk_i        (hclk),
      .rst_i        (hresetn),
      .hwrite_i     (hwrite),
      .hreadyin_i   (hreadyin),
      .htrans_i     (htrans),
      .haddr_i      (haddr),
      .hwdata_i     (hwdata),
      .valid_o      (valid),
      .haddr1_o     (haddr_1),
      .haddr2_o     (haddr_2),
      .hwdata1_o    (hwdata_1),
      .hwrite_reg_o (hwrite_reg)
   );

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d, src_addr;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [2:0]        pselx_q, pselx_d;
   logic              pwrite_q, pwrite_d, penable_q, penable_d, hready_q, hready_d;

   always_ff @(posedge hclk) begin
      if (hresetn) begin
         state_q   <= ST_IDLE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pselx_q   <= SEL_NONE;
         pwrite_q  <= 1'b0;
         penable_q <= 1'b0;
         hready_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pselx_q   <= pselx_d;
         pwrite_q  <= pwrite_d;
         penable_q <= penable_d;
         hready_q  <= hready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_RENABLE, ST_WENABLE:
            if (valid) state_d = hwrite ? ST_WWAIT : ST_READ;
            else       state_d = ST_IDLE;
         ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
         ST_READ:     state_d = ST_RENABLE;
         ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
         ST_WRITEP:   state_d = ST_WENABLEP;
         ST_WENABLEP:
            if (!hwrite_reg) state_d = ST_READ;
            else             state_d = valid ? ST_WRITEP : ST_WRITE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Outputs follow the next state so they are valid while the FSM sits in it.
   // Out of a pipelined write, the pending beat is two address cycles back.
   always_comb begin
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pselx_d   = pselx_q;
      pwrite_d  = pwrite_q;
      penable_d = penable_q;
      hready_d  = hready_q;
      src_addr  = haddr;
      case (state_d)
         ST_IDLE, ST_WWAIT: begin
            pselx_d   = SEL_NONE;
            penable_d = 1'b0;
            hready_d  = 1'b1;
         end
         ST_READ: begin
            src_addr  = (state_q == ST_WENABLEP) ? haddr_2 : haddr;
            paddr_d   = src_addr;
            pwrite_d  = 1'b0;
            pselx_d   = sel_of(src_addr);
            penable_d = 1'b0;
            hready_d  = 1'b0;
         end
         ST_WRITE, ST_WRITEP: begin
            if (state_q == ST_WWAIT) begin
               src_addr = haddr_1;
               pwdata_d = hwdata;
            end else begin
               src_addr = haddr_2;
               pwdata_d = hwdata_1;
            end
            paddr_d   = src_addr;
            pwrite_d  = 1'b1;
            pselx_d   = sel_of(src_addr);
            penable_d = 1'b0;
            hready_d  = 1'b0;
         end
         default: begin
            penable_d = 1'b1;
            hready_d  = 1'b1;
         end
      endcase
   end

   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign pselx     = pselx_q;
   assign pwrite    = pwrite_q;
   assign penable   = penable_q;
   assign hreadyout = hready_q;
   assign hresp     = 2'b00;
   assign hrdata    = prdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: per-cycle vector table plus hand-written
// read-latency and reset-during-burst sequences.
module tb_ahb_apb_bridge;
   import ahb_apb_pkg::*;

   logic        hclk = 1'b0;
   logic        hresetn, hwrite, hreadyin;
   logic [1:0]  htrans;
   logic [31:0] hwdata, haddr, prdata;
   logic        penable, pwrite, hreadyout;
   logic [2:0]  pselx;
   logic [1:0]  hresp;
   logic [31:0] paddr, pwdata, hrdata;

   int checks = 0;
   int errors = 0;

   ahb_apb_bridge dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hwrite    (hwrite),
      .hreadyin  (hreadyin),
      .htrans    (htrans),
      .hwdata    (hwdata),
      .haddr     (haddr),
      .prdata    (prdata),
      .penable   (penable),
      .pwrite    (pwrite),
      .hreadyout (hreadyout),
      .pselx     (pselx),
      .hresp     (hresp),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .hrdata    (hrdata)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic        rst;
      logic [1:0]  tr;
      logic        wr;
      logic        rdy;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [2:0]  sel;
      logic        en;
      logic        pw;
      logic        ro;
      logic [31:0] pa;
      logic [31:0] pd;
   } vec_t;

   vec_t tbl[$];

   localparam logic [1:0] ID = HTRANS_IDLE, BZ = HTRANS_BUSY;
   localparam logic [1:0] NS = HTRANS_NONSEQ, SQ = HTRANS_SEQ;

   function automatic vec_t mk(input logic rst, input logic [1:0] tr, input logic wr,
                               input logic rdy, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [2:0] sel, input logic en, input logic pw,
                               input logic ro, input logic [31:0] pa, input logic [31:0] pd);
      vec_t v;
      v.rst = rst; v.tr = tr; v.wr = wr; v.rdy = rdy; v.addr = addr; v.wd = wd;
      v.sel = sel; v.en = en; v.pw = pw; v.ro = ro; v.pa = pa; v.pd = pd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [1:0] tr, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd);
      hresetn  = rst;
      htrans   = tr;
      hwrite   = wr;
      hreadyin = 1'b1;
      haddr    = addr;
      hwdata   = wd;
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   localparam logic [31:0] WA = 32'h8000_0000, WD = 32'hA5A5_A5A5, RA = 32'h8400_0010;
   localparam logic [31:0] B  = 32'h8800_0000, P  = 32'h8000_0004, PD = 32'hCAFE_0004;
   localparam logic [31:0] Q  = 32'h8000_0008, K  = 32'h8BFF_FFFC;

   initial begin
      int n;
      //                rst tr  wr rdy addr        wd    sel     en pw ro  paddr   pwdata
      tbl.push_back(mk(1, ID, 0, 1, 0,           0,    3'b000, 0, 0, 1, 0,      0));
      // single write
      tbl.push_back(mk(0, NS, 1, 1, WA,          0,    3'b000, 0, 0, 1, 0,      0));
      tbl.push_back(mk(0, ID, 1, 1, WA,          WD,   3'b001, 0, 1, 0, WA,     WD));
      tbl.push_back(mk(0, ID, 1, 1, WA,          WD,   3'b001, 1, 1, 1, WA,     WD));
      tbl.push_back(mk(0, ID, 1, 1, WA,          WD,   3'b000, 0, 1, 1, WA,     WD));
      // single read
      tbl.push_back(mk(0, NS, 0, 1, RA,          WD,   3'b010, 0, 0, 0, RA,     WD));
      tbl.push_back(mk(0, ID, 0, 1, RA,          WD,   3'b010, 1, 0, 1, RA,     WD));
      tbl.push_back(mk(0, ID, 0, 1, RA,          WD,   3'b000, 0, 0, 1, RA,     WD));
      // INCR4 write, master stalls while hreadyout is low
      tbl.push_back(mk(0, NS, 1, 1, B,           WD,   3'b000, 0, 0, 1, RA,     WD));
      tbl.push_back(mk(0, SQ, 1, 1, B+4,         1,    3'b100, 0, 1, 0, B,      1));
      tbl.push_back(mk(0, SQ, 1, 1, B+8,         2,    3'b100, 1, 1, 1, B,      1));
      tbl.push_back(mk(0, SQ, 1, 1, B+8,         2,    3'b100, 0, 1, 0, B+4,    2));
      tbl.push_back(mk(0, SQ, 1, 1, B+12,        3,    3'b100, 1, 1, 1, B+4,    2));
      tbl.push_back(mk(0, SQ, 1, 1, B+12,        3,    3'b100, 0, 1, 0, B+8,    3));
      tbl.push_back(mk(0, ID, 1, 1, B+12,        4,    3'b100, 1, 1, 1, B+8,    3));
      tbl.push_back(mk(0, ID, 1, 1, B+12,        4,    3'b100, 0, 1, 0, B+12,   4));
      tbl.push_back(mk(0, ID, 1, 1, B+12,        4,    3'b100, 1, 1, 1, B+12,   4));
      tbl.push_back(mk(0, ID, 1, 1, B+12,        4,    3'b000, 0, 1, 1, B+12,   4));
      // write followed directly by read
      tbl.push_back(mk(0, NS, 1, 1, P,           4,    3'b000, 0, 1, 1, B+12,   4));
      tbl.push_back(mk(0, NS, 0, 1, Q,           PD,   3'b001, 0, 1, 0, P,      PD));
      tbl.push_back(mk(0, ID, 0, 1, Q,           PD,   3'b001, 1, 1, 1, P,      PD));
      tbl.push_back(mk(0, ID, 0, 1, Q,           PD,   3'b001, 0, 0, 0, Q,      PD));
      tbl.push_back(mk(0, ID, 0, 1, Q,           PD,   3'b001, 1, 0, 1, Q,      PD));
      tbl.push_back(mk(0, ID, 0, 1, Q,           PD,   3'b000, 0, 0, 1, Q,      PD));
      // ignored transfers, then top-of-window read
      tbl.push_back(mk(0, NS, 1, 1, 32'h9000_0000, PD, 3'b000, 0, 0, 1, Q,      PD));
      tbl.push_back(mk(0, ID, 1, 1, WA,          PD,   3'b000, 0, 0, 1, Q,      PD));
      tbl.push_back(mk(0, BZ, 1, 1, WA,          PD,   3'b000, 0, 0, 1, Q,      PD));
      tbl.push_back(mk(0, NS, 1, 0, WA,          PD,   3'b000, 0, 0, 1, Q,      PD));
      tbl.push_back(mk(0, NS, 0, 1, 32'h8C00_0000, PD, 3'b000, 0, 0, 1, Q,      PD));
      tbl.push_back(mk(0, NS, 0, 1, 32'h7FFF_FFFC, PD, 3'b000, 0, 0, 1, Q,      PD));
      tbl.push_back(mk(0, NS, 0, 1, K,           PD,   3'b100, 0, 0, 0, K,      PD));
      tbl.push_back(mk(0, ID, 0, 1, K,           PD,   3'b100, 1, 0, 1, K,      PD));
      tbl.push_back(mk(0, ID, 0, 1, K,           PD,   3'b000, 0, 0, 1, K,      PD));
      // reset while in READ
      tbl.push_back(mk(0, NS, 0, 1, WA,          PD,   3'b001, 0, 0, 0, WA,     PD));
      tbl.push_back(mk(1, ID, 0, 1, WA,          PD,   3'b000, 0, 0, 1, 0,      0));
      tbl.push_back(mk(0, ID, 0, 1, WA,          PD,   3'b000, 0, 0, 1, 0,      0));

      prdata = 32'h1234_5678;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].tr, tbl[i].wr, tbl[i].addr, tbl[i].wd);
         hreadyin = tbl[i].rdy;
         step();
         chk($sformatf("row%0d", i), {pselx, penable, pwrite, hreadyout, paddr, pwdata},
             {tbl[i].sel, tbl[i].en, tbl[i].pw, tbl[i].ro, tbl[i].pa, tbl[i].pd});
         chk($sformatf("row%0d_resp", i), {hresp, hrdata}, {2'b00, 32'h1234_5678});
      end

      // read latency: ACCESS two cycles after the address phase
      prdata = 32'hDEAD_BEEF;
      drive(0, NS, 0, 32'h8800_0040, 0);
      step();
      n = 1;
      drive(0, ID, 0, 32'h8800_0040, 0);
      while (!penable && n < 8) begin
         step();
         n++;
      end
      chk("rd_access_seen", penable, 1'b1);
      chk("rd_latency", n, 2);
      chk("rd_access", {pselx, hreadyout, hrdata}, {3'b100, 1'b1, 32'hDEAD_BEEF});
      prdata = 32'h0BAD_F00D;
      #1;
      chk("rd_hrdata_comb", hrdata, 32'h0BAD_F00D);
      step();
      chk("rd_done", {pselx, penable, hreadyout}, {3'b000, 1'b0, 1'b1});

      // reset in the middle of a pipelined write burst
      drive(0, NS, 1, 32'h8000_0100, 0);
      step();
      drive(0, SQ, 1, 32'h8000_0104, 32'h11);
      step();
      chk("burst_setup", {pselx, penable, paddr, pwdata}, {3'b001, 1'b0, 32'h8000_0100, 32'h11});
      drive(0, SQ, 1, 32'h8000_0108, 32'h22);
      step();
      chk("burst_access", {pselx, penable, hreadyout}, {3'b001, 1'b1, 1'b1});
      drive(1, SQ, 1, 32'h8000_0108, 32'h22);
      step();
      chk("burst_reset", {pselx, penable, pwrite, hreadyout, paddr, pwdata},
          {3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0});
      drive(0, ID, 1, 32'h8000_0108, 32'h22);
      step();
      chk("post_reset_idle", {pselx, penable, hreadyout}, {3'b000, 1'b0, 1'b1});
      drive(0, NS, 1, 32'h8400_0020, 0);
      step();
      drive(0, ID, 1, 32'h8400_0020, 32'h5A);
      step();
      chk("post_reset_write", {pselx, penable, pwrite, hreadyout, paddr, pwdata},
          {3'b010, 1'b0, 1'b1, 1'b0, 32'h8400_0020, 32'h5A});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
